alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter ZERO_R0, default 1, meaning register R0 reads as 0 and ignores writes when 1.
REQ-002 The block SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port instr  input  16  instruction word.
REQ-005 The block SHALL have port instr_valid  input  1  instruction offered.
REQ-006 The block SHALL have port instr_ready  output  1  block can accept an instruction.
REQ-007 The block SHALL have port ScrA  output  32  ALU operand A, registered.
REQ-008 The block SHALL have port ScrB  output  32  ALU operand B, registered.
REQ-009 The block SHALL have port ALUControl  output  1  0 = add/move, 1 = subtract, registered.
REQ-010 The block SHALL have port InstrCode  output  3  opcode presented to the ALU, registered.
REQ-011 The block SHALL have port ALUResult  input  32  ALU result, combinational from ScrA/ScrB/ALUControl/InstrCode.
REQ-012 The block SHALL have port ALUFlags  input  1  ALU zero flag.
REQ-013 The block SHALL have port done  output  1  one-cycle pulse at instruction completion.
REQ-014 The block SHALL have port err  output  1  one-cycle pulse with done for an illegal opcode.
REQ-015 The block SHALL have port z_flag  output  1  architectural zero flag.

Function
REQ-016 Decode: opcode=instr[15:13], Rd=instr[12:10], Rn=instr[9:7], Rm=instr[6:4], imm=instr[9:0] zero-extended to 32 bits.
REQ-017 Opcodes: 000 ADD, 001 SUB, 010 MOV (Rd=Rm), 011 CMP (SUB, no writeback), 100 MOVI (Rd=imm); 101-111 illegal.
REQ-018 The FSM SHALL have states IDLE, READ, EXEC and WB, in that order, then return to IDLE.
REQ-019 instr_ready SHALL be 1 only in IDLE; an instruction is accepted on a rising edge with instr_valid=1 and instr_ready=1, and the word is latched.
REQ-020 On the edge leaving READ, ScrA=R[Rn] and ScrB=R[Rm] (imm for MOVI) SHALL be loaded.
REQ-021 On the same edge, ALUControl=1 for SUB/CMP (else 0) and InstrCode=010 for MOV/MOVI, else opcode, SHALL be loaded.
REQ-022 On the edge leaving EXEC, ALUResult and ALUFlags SHALL be captured.
REQ-023 In WB, done=1; on the edge leaving WB, R[Rd] SHALL be written for ADD/SUB/MOV/MOVI, and z_flag SHALL take the captured flag for all legal opcodes.
REQ-024 Latency: done SHALL be high in the third cycle after the accept edge; the next accept is possible in the cycle after done (4 cycles per instruction).
REQ-025 An illegal opcode SHALL traverse the same states with ALU ports held, no register write, z_flag unchanged, and err=1 together with done.
REQ-026 ADD/SUB SHALL wrap modulo 2^32; no carry or overflow is kept.
REQ-027 With ZERO_R0=1, R0 reads SHALL return 0 and writes to R0 SHALL be dropped (z_flag still updates).
REQ-028 The source operands in READ SHALL reflect the write performed by the immediately preceding WB.

Reset
REQ-029 Reset SHALL force state IDLE, R0-R7=0, z_flag=0, and ScrA=ScrB=0, ALUControl=0, InstrCode=0, done=0, err=0.
REQ-030 Reset asserted mid-instruction SHALL abort the instruction with no writeback and no done.
REQ-031 instr_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-032 With ALU_SEQ_DBG_PORT_EN defined, the block SHALL have ports dbg_addr (input, 3 bits) and dbg_data (output, 32 bits), where dbg_data is a combinational read of R[dbg_addr] honouring ZERO_R0.
REQ-033 Without ALU_SEQ_DBG_PORT_EN, those ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 A shared package alu_seq_pkg SHALL hold the opcode constants, the FSM state enum and the instruction field bit positions.
REQ-035 The register file SHALL be the sub-module regfile8x32: 2 asynchronous read ports, 1 synchronous write port, asynchronous reset.
REQ-036 The ALU SHALL be external to this block; the bench SHALL connect it to the ALU port set.

Verification
REQ-037 After reset: MOVI R1,5 -> done in cycle 3 after accept; R1=5; z_flag=0; err=0.
REQ-038 MOVI R1,5; MOVI R2,5; CMP R1,R2 -> ScrA=5, ScrB=5, ALUControl=1 in EXEC; z_flag=1; R0-R2 unchanged by CMP.
REQ-039 MOVI R3,0; SUB R4,R3,R1 (R1=1) -> R4=0xFFFFFFFF; z_flag=0.
REQ-040 Opcode 111 -> err=1 with done; registers and z_flag unchanged; instr_ready=0 for 3 cycles.
REQ-041 ZERO_R0=1: MOVI R0,7 -> R0 reads 0; z_flag=0.
REQ-042 ADD accepted, reset asserted in EXEC -> no done; Rd=0 after reset; instr_ready=1 the first cycle after reset deasserts.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and instruction field layout.
package alu_seq_pkg;

  localparam int DATA_W  = 32;
  localparam int INSTR_W = 16;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RD_HI  = 12;
  localparam int RD_LO  = 10;
  localparam int RN_HI  = 9;
  localparam int RN_LO  = 7;
  localparam int RM_HI  = 6;
  localparam int RM_LO  = 4;
  localparam int IMM_HI = 9;
  localparam int IMM_LO = 0;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b010;
  localparam logic [2:0] OP_CMP  = 3'b011;
  localparam logic [2:0] OP_MOVI = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  function automatic logic is_legal(input logic [2:0] op);
    return (op <= OP_MOVI);
  endfunction

  function automatic logic writes_rd(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MOV) || (op == OP_MOVI);
  endfunction

endpackage

// File: rtl/regfile8x32.sv
// Eight 32-bit registers: two asynchronous read ports, one synchronous write port.
// ALU_SEQ_DBG_PORT_EN adds a third asynchronous read port for debug.
module regfile8x32
  import alu_seq_pkg::*;
#(
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic [2:0]        ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [2:0]        wa,
  input  logic [DATA_W-1:0] wd
`ifdef ALU_SEQ_DBG_PORT_EN
  ,
  input  logic [2:0]        ra3,
  output logic [DATA_W-1:0] rd3
`endif
);

  logic [DATA_W-1:0] regs [8];
  logic              r0_hard;

  assign r0_hard = (ZERO_R0 != 0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (we && !(r0_hard && (wa == 3'd0))) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (r0_hard && (ra1 == 3'd0)) ? '0 : regs[ra1];
  assign rd2 = (r0_hard && (ra2 == 3'd0)) ? '0 : regs[ra2];

`ifdef ALU_SEQ_DBG_PORT_EN
  assign rd3 = (r0_hard && (ra3 == 3'd0)) ? '0 : regs[ra3];
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer driving an external ALU and an 8x32 register file.
// Define ALU_SEQ_DBG_PORT_EN to expose the dbg_addr/dbg_data register read port.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ZERO_R0 = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [31:0] ScrA,
  output logic [31:0] ScrB,
  output logic        ALUControl,
  output logic [2:0]  InstrCode,
  input  logic [31:0] ALUResult,
  input  logic        ALUFlags,
  output logic        done,
  output logic        err,
  output logic        z_flag
`ifdef ALU_SEQ_DBG_PORT_EN
  ,
  input  logic [2:0]  dbg_addr,
  output logic [31:0] dbg_data
`endif
);

  state_t            state;
  logic [15:0]       ir_p0;
  logic [31:0]       res_p2;
  logic              flag_p2;

  logic [2:0]        op;
  logic [2:0]        rd;
  logic [2:0]        rn;
  logic [2:0]        rm;
  logic [31:0]       imm;
  logic [31:0]       rdata_a;
  logic [31:0]       rdata_b;
  logic              rf_we;

  assign op  = ir_p0[OP_HI:OP_LO];
  assign rd  = ir_p0[RD_HI:RD_LO];
  assign rn  = ir_p0[RN_HI:RN_LO];
  assign rm  = ir_p0[RM_HI:RM_LO];
  assign imm = {22'd0, ir_p0[IMM_HI:IMM_LO]};

  // Write happens on the edge leaving WB, so the next READ already sees it.
  assign rf_we = (state == S_WB) && writes_rd(op);

  regfile8x32 #(
    .ZERO_R0(ZERO_R0)
  ) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (rn),
    .rd1   (rdata_a),
    .ra2   (rm),
    .rd2   (rdata_b),
    .we    (rf_we),
    .wa    (rd),
    .wd    (res_p2)
`ifdef ALU_SEQ_DBG_PORT_EN
    ,
    .ra3   (dbg_addr),
    .rd3   (dbg_data)
`endif
  );

  // Stage p0: instruction latch; stage p2: ALU result capture (datapath, not reset)
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && instr_valid) ir_p0 <= instr;
    if (state == S_EXEC) begin
      res_p2  <= ALUResult;
      flag_p2 <= ALUFlags;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      instr_ready <= 1'b1;
      ScrA        <= '0;
      ScrB        <= '0;
      ALUControl  <= 1'b0;
      InstrCode   <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      z_flag      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            state       <= S_READ;
            instr_ready <= 1'b0;
          end
        end
        S_READ: begin
          state <= S_EXEC;
          // Illegal opcodes leave the ALU ports untouched.
          if (is_legal(op)) begin
            ScrA       <= rdata_a;
            ScrB       <= (op == OP_MOVI) ? imm : rdata_b;
            ALUControl <= (op == OP_SUB) || (op == OP_CMP);
            InstrCode  <= ((op == OP_MOV) || (op == OP_MOVI)) ? OP_MOV : op;
          end
        end
        S_EXEC: begin
          state <= S_WB;
          done  <= 1'b1;
          err   <= !is_legal(op);
        end
        S_WB: begin
          state       <= S_IDLE;
          instr_ready <= 1'b1;
          done        <= 1'b0;
          err         <= 1'b0;
          if (is_legal(op)) z_flag <= flag_p2;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus randomized bench for alu_sequencer with an external ALU and a reference model.
module tb_alu_sequencer;

  localparam int ZERO_R0 = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] ScrA;
  logic [31:0] ScrB;
  logic        ALUControl;
  logic [2:0]  InstrCode;
  logic [31:0] ALUResult;
  logic        ALUFlags;
  logic        done;
  logic        err;
  logic        z_flag;
`ifdef ALU_SEQ_DBG_PORT_EN
  logic [2:0]  dbg_addr;
  logic [31:0] dbg_data;
`endif

  alu_sequencer #(.ZERO_R0(ZERO_R0)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ScrA        (ScrA),
    .ScrB        (ScrB),
    .ALUControl  (ALUControl),
    .InstrCode   (InstrCode),
    .ALUResult   (ALUResult),
    .ALUFlags    (ALUFlags),
    .done        (done),
    .err         (err),
    .z_flag      (z_flag)
`ifdef ALU_SEQ_DBG_PORT_EN
    ,
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`endif
  );

  always #5 clk = ~clk;

  // External ALU: subtract when ALUControl, pass B for move, otherwise add.
  always_comb begin
    if (ALUControl)              ALUResult = ScrA - ScrB;
    else if (InstrCode == 3'b010) ALUResult = ScrB;
    else                         ALUResult = ScrA + ScrB;
  end
  assign ALUFlags = (ALUResult == 32'd0);

  // Reference model state
  logic [31:0] m_r [8];
  logic        m_z;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_ctl;
  logic [2:0]  m_code;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] obs_a;
  logic [31:0] obs_b;
  logic        saved_z;

  function automatic logic [31:0] rdm(input logic [2:0] r);
    return ((ZERO_R0 != 0) && (r == 3'd0)) ? 32'd0 : m_r[r];
  endfunction

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rn, input logic [2:0] rm);
    return {op, rd, rn, rm, 4'd0};
  endfunction

  function automatic logic [15:0] movi(input logic [2:0] rd, input logic [9:0] imm);
    return {3'b100, rd, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 32'd0;
    m_z = 1'b0; m_a = 32'd0; m_b = 32'd0; m_ctl = 1'b0; m_code = 3'd0;
  endtask

  // Issue one instruction at the current negedge and follow it through all four cycles.
  task automatic issue(input logic [15:0] w);
    logic [2:0]  op;
    logic [2:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] res;
    logic        legal;
    op    = w[15:13];
    rd    = w[12:10];
    imm   = {22'd0, w[9:0]};
    a     = rdm(w[9:7]);
    b     = rdm(w[6:4]);
    legal = (op <= 3'd4);
    res   = 32'd0;
    case (op)
      3'd0: res = a + b;
      3'd1: res = a - b;
      3'd2: res = b;
      3'd3: res = a - b;
      3'd4: res = imm;
      default: res = 32'd0;
    endcase
    if (legal) begin
      m_a    = a;
      m_b    = (op == 3'd4) ? imm : b;
      m_ctl  = (op == 3'd1) || (op == 3'd3);
      m_code = ((op == 3'd2) || (op == 3'd4)) ? 3'd2 : op;
    end
    chk("ready_idle", 32'(instr_ready), 32'd1);
    instr = w; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; instr = 16'($urandom);
    chk("ready_read", 32'(instr_ready), 32'd0);
    chk("done_read", 32'(done), 32'd0);
    @(negedge clk);
    obs_a = ScrA; obs_b = ScrB;
    chk("ScrA", ScrA, m_a);
    chk("ScrB", ScrB, m_b);
    chk("ALUControl", 32'(ALUControl), 32'(m_ctl));
    chk("InstrCode", 32'(InstrCode), 32'(m_code));
    chk("done_exec", 32'(done), 32'd0);
    chk("ready_exec", 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk("done_wb", 32'(done), 32'd1);
    chk("err_wb", 32'(err), 32'(!legal));
    chk("ready_wb", 32'(instr_ready), 32'd0);
    @(negedge clk);
    if (legal) begin
      m_z = (res == 32'd0);
      if ((op != 3'd3) && !((ZERO_R0 != 0) && (rd == 3'd0))) m_r[rd] = res;
    end
    chk("done_idle", 32'(done), 32'd0);
    chk("err_idle", 32'(err), 32'd0);
    chk("z_flag", 32'(z_flag), 32'(m_z));
  endtask

  // Read a register through a CMP r,r and compare with an independently known value.
  task automatic check_reg(input string tag, input logic [2:0] r, input logic [31:0] exp);
`ifdef ALU_SEQ_DBG_PORT_EN
    dbg_addr = r;
    #1 chk({tag, "_dbg"}, dbg_data, exp);
`endif
    issue(enc(3'd3, 3'd0, r, r));
    chk(tag, obs_a, exp);
  endtask

  initial begin
    reset = 1'b1; instr = 16'd0; instr_valid = 1'b0;
`ifdef ALU_SEQ_DBG_PORT_EN
    dbg_addr = 3'd0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ScrA", ScrA, 32'd0);
    chk("rst_ScrB", ScrB, 32'd0);
    chk("rst_ctl", 32'(ALUControl), 32'd0);
    chk("rst_code", 32'(InstrCode), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_z", 32'(z_flag), 32'd0);
    reset = 1'b0;
    chk("rst_ready", 32'(instr_ready), 32'd1);

    // MOVI R1,5 then read back
    issue(movi(3'd1, 10'd5));
    chk("movi_z", 32'(z_flag), 32'd0);
    check_reg("r1_eq5", 3'd1, 32'd5);

    // CMP of two equal registers sets z_flag and writes nothing
    issue(movi(3'd2, 10'd5));
    issue(enc(3'd3, 3'd0, 3'd1, 3'd2));
    chk("cmp_a", obs_a, 32'd5);
    chk("cmp_b", obs_b, 32'd5);
    chk("cmp_z", 32'(z_flag), 32'd1);
    check_reg("cmp_r0", 3'd0, 32'd0);
    check_reg("cmp_r1", 3'd1, 32'd5);
    check_reg("cmp_r2", 3'd2, 32'd5);

    // 0 - 1 wraps to all ones
    issue(movi(3'd3, 10'd0));
    issue(movi(3'd1, 10'd1));
    issue(enc(3'd1, 3'd4, 3'd3, 3'd1));
    chk("sub_wrap_z", 32'(z_flag), 32'd0);
    check_reg("sub_wrap_r4", 3'd4, 32'hFFFF_FFFF);

    // Illegal opcode: err with done, no state change
    issue(movi(3'd6, 10'd0));
    saved_z = z_flag;
    issue(16'hE000 | 16'h1234);
    chk("ill_z_kept", 32'(z_flag), 32'(saved_z));
    check_reg("ill_r6", 3'd6, 32'd0);

    // R0 is hardwired to zero
    issue(movi(3'd0, 10'd7));
    chk("r0_z", 32'(z_flag), 32'd0);
    check_reg("r0_zero", 3'd0, 32'd0);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      logic [15:0] w;
      w = 16'($urandom);
      w[15:13] = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      issue(w);
    end
    for (int r = 0; r < 8; r++) check_reg("rand_reg", 3'(r), rdm(3'(r)));

    // Reset while an ADD is in EXEC aborts it
    issue(movi(3'd1, 10'd3));
    issue(movi(3'd2, 10'd4));
    instr = enc(3'd0, 3'd5, 3'd1, 3'd2); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 chk("abort_done0", 32'(done), 32'd0);
    @(negedge clk);
    chk("abort_done1", 32'(done), 32'd0);
    reset = 1'b0;
    model_reset();
    chk("abort_ready", 32'(instr_ready), 32'd1);
    chk("abort_ScrA", ScrA, 32'd0);
    check_reg("abort_r5", 3'd5, 32'd0);
    check_reg("abort_r1", 3'd1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
